// File: rtl/traffic_pkg.sv
// Shared lane indexing and queue-update decode for the traffic controller slice.
package traffic_pkg;

  localparam int LANE_NS   = 0;
  localparam int LANE_SN   = 1;
  localparam int LANE_EW   = 2;
  localparam int LANE_WE   = 3;
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {
    Q_HOLD = 2'b00,
    Q_INC  = 2'b01,
    Q_DEC  = 2'b10
  } q_op_e;

  // Simultaneous arrival and departure cancel out.
  function automatic q_op_e q_op(input logic arr_evt, input logic dep_evt);
    case ({arr_evt, dep_evt})
      2'b10:   return Q_INC;
      2'b01:   return Q_DEC;
      default: return Q_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/lane_sensor_channel.sv
// One approach: arrival/departure sync + debounce + rising-edge event,
// feeding a saturating queue counter with registered S1/S5 flags.
module lane_sensor_channel
  import traffic_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 6,
  parameter int LONG_Q     = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arr_raw,
  input  logic             dep_raw,
  output logic             s1,
  output logic             s5,
  output logic [CNT_W-1:0] q_count
);

  localparam int              DW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DW-1:0]   DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_Q_C = CNT_W'(LONG_Q);

  logic [1:0] raw;
  logic [1:0] evt;

  assign raw = {dep_raw, arr_raw};

  for (genvar p = 0; p < 2; p++) begin : g_path
    logic          sync1;
    logic          sync2;
    logic          stable;
    logic          evt_q;
    logic [DW-1:0] run;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync1  <= 1'b0;
        sync2  <= 1'b0;
        stable <= 1'b0;
        evt_q  <= 1'b0;
        run    <= '0;
      end else begin
        sync1 <= raw[p];
        sync2 <= sync1;
        evt_q <= 1'b0;
        if (sync2 == stable) begin
          run <= '0;
        end else if (run == DEB_LAST) begin
          // Event fires only when the accepted level is a rise.
          stable <= sync2;
          run    <= '0;
          evt_q  <= sync2;
        end else begin
          run <= run + 1'b1;
        end
      end
    end

    assign evt[p] = evt_q;
  end

  q_op_e            op;
  logic [CNT_W-1:0] count_nxt;

  always_comb begin
    op        = q_op(evt[0], evt[1]);
    count_nxt = q_count;
    case (op)
      Q_INC:   if (q_count != '1) count_nxt = q_count + 1'b1;
      Q_DEC:   if (q_count != '0) count_nxt = q_count - 1'b1;
      default: count_nxt = q_count;
    endcase
  end

  // Flags are registered from the next count so they move with q_count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_count <= '0;
      s1      <= 1'b0;
      s5      <= 1'b0;
    end else begin
      q_count <= count_nxt;
      s1      <= (count_nxt != '0);
      s5      <= (count_nxt >= LONG_Q_C);
    end
  end

endmodule

// File: rtl/lane_queue_sensor.sv
// Four-approach queue sensor producing the S1 (waiting) and S5 (long queue)
// inputs of the traffic light controller.
module lane_queue_sensor
  import traffic_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int CNT_W      = 6,
  parameter int LONG_Q     = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_LANES-1:0]       arr_raw,
  input  logic [NUM_LANES-1:0]       dep_raw,
  output logic                       NS_S1,
  output logic                       SN_S1,
  output logic                       EW_S1,
  output logic                       WE_S1,
  output logic                       NS_S5,
  output logic                       SN_S5,
  output logic                       EW_S5,
  output logic                       WE_S5,
  output logic [NUM_LANES*CNT_W-1:0] q_count
);

  logic [NUM_LANES-1:0] s1;
  logic [NUM_LANES-1:0] s5;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_sensor_channel #(
      .DEB_CYCLES(DEB_CYCLES),
      .CNT_W     (CNT_W),
      .LONG_Q    (LONG_Q)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .arr_raw(arr_raw[i]),
      .dep_raw(dep_raw[i]),
      .s1     (s1[i]),
      .s5     (s5[i]),
      .q_count(q_count[i*CNT_W +: CNT_W])
    );
  end

  assign NS_S1 = s1[LANE_NS];
  assign SN_S1 = s1[LANE_SN];
  assign EW_S1 = s1[LANE_EW];
  assign WE_S1 = s1[LANE_WE];
  assign NS_S5 = s5[LANE_NS];
  assign SN_S5 = s5[LANE_SN];
  assign EW_S5 = s5[LANE_EW];
  assign WE_S5 = s5[LANE_WE];

endmodule
